queue_frame_stats: RTL and testbench

- Front-end stage of the queue-method path. Collects a frame of signed integers over a valid/ready stream into a bounded buffer.
- While loading, it accumulates size, sum and minimum.
- After the last beat it sorts the buffer ascending in place, then presents a result record (size, sum, min, max, overflow) with a valid/ready handshake.
- While the result is held, the sorted contents are readable by index. Downstream push/tail logic consumes the result.

---
 rtl/queue_frame_stats.sv | 131 +++++++++++++
 tb/tb_queue_frame_stats.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/queue_frame_stats.sv
// Frame collector: loads a bounded frame of signed values, tracks size/sum/min,
// sorts it in place with a fixed-latency odd-even transposition, then presents the result.
module queue_frame_stats #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_size,
  output logic [DATA_W-1:0] out_sum,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic              out_ovf,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  // state | meaning
  // LOAD  | accepting beats, accumulating size/sum/min
  // SORT  | DEPTH compare-swap passes over mem[0..count-1]
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {LOAD, SORT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] sort_nxt [DEPTH];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  pass_left;
  logic              odd_pass;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] max_val;
  logic [DATA_W-1:0] last_elem;
  logic              ovf;
  logic              valid_q;

  assign in_ready  = (state == LOAD) && !rst;
  assign out_valid = valid_q;
  assign out_size  = count;
  assign out_sum   = sum;
  assign out_min   = min_val;
  assign out_max   = max_val;
  assign out_ovf   = ovf;

  // One transposition pass; pairs reaching past count are left untouched.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) sort_nxt[i] = mem[i];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (((i % 2) == 1) == odd_pass && CNT_W'(i + 1) < count &&
          $signed(mem[i]) > $signed(mem[i+1])) begin
        sort_nxt[i]   = mem[i+1];
        sort_nxt[i+1] = mem[i];
      end
    end
  end

  always_comb begin
    last_elem = '0;
    rd_data   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i + 1) == count) last_elem = mem[i];
      if (CNT_W'(i) == rd_idx && CNT_W'(i) < count) rd_data = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      count     <= '0;
      pass_left <= '0;
      odd_pass  <= 1'b0;
      sum       <= '0;
      min_val   <= '0;
      max_val   <= '0;
      ovf       <= 1'b0;
      valid_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (count < CNT_W'(DEPTH)) begin
              for (int i = 0; i < DEPTH; i++)
                if (CNT_W'(i) == count) mem[i] <= in_data;
              count <= count + 1'b1;
              sum   <= sum + in_data;
              if (count == '0 || $signed(in_data) < $signed(min_val))
                min_val <= in_data;
            end else begin
              ovf <= 1'b1;
            end
            if (in_last) begin
              state     <= SORT;
              pass_left <= CNT_W'(DEPTH);
              odd_pass  <= 1'b0;
            end
          end
        end
        SORT: begin
          if (pass_left != '0) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= sort_nxt[i];
            pass_left <= pass_left - 1'b1;
            odd_pass  <= ~odd_pass;
          end else begin
            state   <= DONE;
            valid_q <= 1'b1;
            max_val <= last_elem;
          end
        end
        DONE: begin
          if (out_ready) begin
            state   <= LOAD;
            valid_q <= 1'b0;
            count   <= '0;
            sum     <= '0;
            ovf     <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_frame_stats.sv
// Directed bench for queue_frame_stats: table of frames with hand-computed results,
// plus hand-written hold, latency and mid-sort reset sequences.
module tb_queue_frame_stats;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_size;
  logic [DATA_W-1:0] out_sum;
  logic [DATA_W-1:0] out_min;
  logic [DATA_W-1:0] out_max;
  logic              out_ovf;
  logic [CNT_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;

  queue_frame_stats #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_size(out_size), .out_sum(out_sum), .out_min(out_min), .out_max(out_max),
    .out_ovf(out_ovf), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] d   [10];
    int          size;
    logic [31:0] sum;
    logic [31:0] min;
    logic [31:0] max;
    logic        ovf;
    logic [31:0] srt [8];
  } vec_t;

  vec_t vecs [5];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    check("in_ready_on_beat", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid_low", 32'(out_valid), 32'd0);
    check("hs_in_ready_high", 32'(in_ready), 32'd1);
    check("hs_size_cleared", 32'(out_size), 32'd0);
    check("hs_sum_cleared", out_sum, 32'd0);
    check("hs_ovf_cleared", 32'(out_ovf), 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; rd_idx = '0;

    vecs[0].n = 5;  vecs[0].d = '{1, 5, 2, 8, 3, 0, 0, 0, 0, 0};
    vecs[0].size = 5; vecs[0].sum = 19; vecs[0].min = 1; vecs[0].max = 8; vecs[0].ovf = 1'b0;
    vecs[0].srt = '{1, 2, 3, 5, 8, 0, 0, 0};
    vecs[1].n = 1;  vecs[1].d = '{-7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].size = 1; vecs[1].sum = -7; vecs[1].min = -7; vecs[1].max = -7; vecs[1].ovf = 1'b0;
    vecs[1].srt = '{-7, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].n = 10; vecs[2].d = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    vecs[2].size = 8; vecs[2].sum = 36; vecs[2].min = 1; vecs[2].max = 8; vecs[2].ovf = 1'b1;
    vecs[2].srt = '{1, 2, 3, 4, 5, 6, 7, 8};
    vecs[3].n = 2;  vecs[3].d = '{32'h7FFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3].size = 2; vecs[3].sum = 32'h80000000; vecs[3].min = 1; vecs[3].max = 32'h7FFFFFFF;
    vecs[3].ovf = 1'b0; vecs[3].srt = '{1, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0};
    vecs[4].n = 3;  vecs[4].d = '{-3, 4, -3, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].size = 3; vecs[4].sum = -2; vecs[4].min = -3; vecs[4].max = 4; vecs[4].ovf = 1'b0;
    vecs[4].srt = '{-3, -3, 4, 0, 0, 0, 0, 0};

    @(posedge clk); #1;
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_size", 32'(out_size), 32'd0);
    check("rst_sum", out_sum, 32'd0);
    check("rst_min", out_min, 32'd0);
    check("rst_max", out_max, 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);

    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vecs[v].n; b++)
        send_beat(vecs[v].d[b], b == vecs[v].n - 1);
      wait_valid(cyc);
      check("latency", cyc, DEPTH + 1);
      check("size", 32'(out_size), vecs[v].size);
      check("sum", out_sum, vecs[v].sum);
      check("min", out_min, vecs[v].min);
      check("max", out_max, vecs[v].max);
      check("ovf", 32'(out_ovf), 32'(vecs[v].ovf));
      for (int k = 0; k < vecs[v].size; k++) begin
        rd_idx = CNT_W'(k); #1;
        check("rd_sorted", rd_data, vecs[v].srt[k]);
      end
      rd_idx = CNT_W'(vecs[v].size); #1;
      check("rd_past_count", rd_data, 32'd0);
      // Hold the result while junk beats are offered; both must be ignored.
      in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
      for (int h = 0; h < 5; h++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_sum", out_sum, vecs[v].sum);
        check("hold_max", out_max, vecs[v].max);
        check("hold_size", 32'(out_size), vecs[v].size);
      end
      in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      handshake();
    end

    // Reset during the third sort pass aborts the frame.
    send_beat(32'd9, 1'b0);
    send_beat(32'd1, 1'b0);
    send_beat(32'd5, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_size", 32'(out_size), 32'd0);
    check("abort_sum", out_sum, 32'd0);
    cyc = 0;
    for (int w = 0; w < 15; w++) begin
      @(posedge clk); #1;
      if (out_valid) cyc++;
    end
    check("abort_no_valid", cyc, 0);

    send_beat(32'd4, 1'b0);
    send_beat(32'd2, 1'b1);
    wait_valid(cyc);
    check("post_size", 32'(out_size), 32'd2);
    check("post_sum", out_sum, 32'd6);
    check("post_min", out_min, 32'd2);
    check("post_max", out_max, 32'd4);
    check("post_ovf", 32'(out_ovf), 32'd0);
    rd_idx = 0; #1;
    check("post_rd0", rd_data, 32'd2);
    rd_idx = 1; #1;
    check("post_rd1", rd_data, 32'd4);
    handshake();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
